// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The FSM encoding, frame constants and a state-class helper live here.
package im_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         IM_WORDS  = 2048;
    localparam int         HDR_LEN   = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_WR   = 3'd4,
        ST_CHK  = 3'd5,
        ST_DONE = 3'd6,
        ST_ERR  = 3'd7
    } state_e;

    // States in which a SYNC byte opens a new frame.
    function automatic logic is_rest_state(input logic [2:0] s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input handshake plus IM write port of the loader.
// master = stream source / IM side, slave = the loader itself.
interface im_loader_if
    import im_loader_pkg::*;
#(
    parameter int AW = $clog2(IM_WORDS)
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          im_we;
    logic [AW-1:0] im_waddr;
    logic [31:0]   im_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, im_we, im_waddr, im_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, im_we, im_waddr, im_wdata
    );
endinterface

// File: rtl/im_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words.
// o_word_full flags the byte that completes the current word.
module im_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);
    logic [1:0] r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_idx <= 2'd0;
        else if (i_clear)
            r_idx <= 2'd0;
        else if (i_load)
            r_idx <= r_idx + 2'd1;
    end

    // Lanes hold their bytes after the 4th load so the word stays valid for the write cycle.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_lane;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_lane <= 8'h00;
            else if (i_clear)
                r_lane <= 8'h00;
            else if (i_load && (r_idx == 2'(gi)))
                r_lane <= i_byte;
        end

        assign o_word[gi*8 +: 8] = r_lane;
    end

    assign o_word_full = i_load && (r_idx == 2'd3);

endmodule

// File: rtl/im_loader.sv
// Framed byte-stream loader: SYNC, 16-bit word count, data, XOR checksum.
// Writes words to IM from address 0 and releases the CPU only after a good frame.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int         IM_DEPTH = IM_WORDS,
    parameter int         AW       = $clog2(IM_DEPTH),
    parameter logic [7:0] SYNC     = SYNC_BYTE
) (
    input  logic        clk,
    input  logic        rst,
    im_loader_if.slave  bus,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_LEN0 = ST_LEN0;
    localparam logic [2:0] S_LEN1 = ST_LEN1;
    localparam logic [2:0] S_DATA = ST_DATA;
    localparam logic [2:0] S_WR   = ST_WR;
    localparam logic [2:0] S_CHK  = ST_CHK;
    localparam logic [2:0] S_DONE = ST_DONE;
    localparam logic [2:0] S_ERR  = ST_ERR;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [15:0] r_len;
    logic [AW:0] r_wcnt;
    logic [7:0]  r_csum;
    logic        r_cpu_rst;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_in_ready;
    logic        w_xfer;
    logic        w_start;
    logic [15:0] w_len_full;
    logic        w_last_word;
    logic        w_pack_load;
    logic [31:0] w_word;
    logic        w_word_full;

    assign w_in_ready  = rst && (r_state != S_WR);
    assign w_xfer      = bus.in_valid && w_in_ready;
    assign w_start     = w_xfer && (bus.in_data == SYNC) && is_rest_state(r_state);
    assign w_len_full  = {bus.in_data, r_len[7:0]};
    assign w_last_word = (16'(r_wcnt) + 16'd1) == r_len;
    assign w_pack_load = w_xfer && (r_state == S_DATA);

    im_byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst),
        .i_clear     (w_start),
        .i_load      (w_pack_load),
        .i_byte      (bus.in_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (w_start) w_state_next = S_LEN0;
            S_LEN0: if (w_xfer) w_state_next = S_LEN1;
            S_LEN1: begin
                if (w_xfer) begin
                    if (w_len_full > 16'(IM_DEPTH))
                        w_state_next = S_ERR;
                    else if (w_len_full == 16'd0)
                        w_state_next = S_CHK;
                    else
                        w_state_next = S_DATA;
                end
            end
            S_DATA: if (w_word_full) w_state_next = S_WR;
            S_WR:   w_state_next = w_last_word ? S_CHK : S_DATA;
            S_CHK: begin
                if (w_xfer)
                    w_state_next = (bus.in_data == r_csum) ? S_DONE : S_ERR;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_len   <= 16'd0;
            r_wcnt  <= '0;
            r_csum  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_len  <= 16'd0;
                r_wcnt <= '0;
                r_csum <= 8'h00;
            end else begin
                if (w_xfer && (r_state == S_LEN0)) r_len[7:0]  <= bus.in_data;
                if (w_xfer && (r_state == S_LEN1)) r_len[15:8] <= bus.in_data;
                if (w_pack_load)                   r_csum      <= r_csum ^ bus.in_data;
                if (r_state == S_WR)               r_wcnt      <= r_wcnt + 1'b1;
            end
        end
    end

    // Status flags are registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cpu_rst <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_cpu_rst <= (w_state_next == S_DONE);
            r_done    <= (w_state_next == S_DONE);
            r_err     <= (w_state_next == S_ERR);
            r_busy    <= !is_rest_state(w_state_next);
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.im_we    = (r_state == S_WR);
    assign bus.im_waddr = r_wcnt[AW-1:0];
    assign bus.im_wdata = w_word;

    assign cpu_rst = r_cpu_rst;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_im_loader.sv
// Scenario bench for im_loader: expected IM writes are queued as frames are sent
// and popped by a write monitor; status flags are checked inline per scenario.
module tb_im_loader;
    import im_loader_pkg::*;

    localparam int AW = 11;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_rst, busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    wr_t        sb[$];
    logic [7:0] txq[$];

    im_loader_if #(.AW(AW)) bus ();

    im_loader #(.IM_DEPTH(2048), .AW(AW), .SYNC(8'hA5)) dut (
        .clk     (clk),
        .rst     (rst_n),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write monitor: every IM write must match the oldest queued expectation.
    always @(negedge clk) begin
        wr_t exp;
        if (bus.im_we === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                         bus.im_waddr, bus.im_wdata);
            end else begin
                exp = sb.pop_front();
                $display("write addr=%0d data=%h", bus.im_waddr, bus.im_wdata);
                if (bus.im_waddr !== exp.addr || bus.im_wdata !== exp.data) begin
                    n_fail++;
                    $display("FAIL write_value: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.im_waddr, bus.im_wdata, exp.addr, exp.data);
                end
            end
        end
        if (rst_n === 1'b1) begin
            n_checks++;
            if (bus.in_ready !== ~bus.im_we) begin
                n_fail++;
                $display("FAIL ready_vs_wr: got in_ready=%b im_we=%b, required in_ready=!im_we",
                         bus.in_ready, bus.im_we);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the transfer.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int tries = 0;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got in_ready=%b for 20 cycles, required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        $display("byte %h accepted", b);
    endtask

    task automatic send_txq(input bit gaps);
        foreach (txq[i]) send_byte(txq[i], gaps);
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.im_we, bus.im_waddr, bus.im_wdata, cpu_rst, busy, done, err, bus.in_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%h cpu_rst=%b busy=%b done=%b err=%b rdy=%b, required all 0",
                     bus.im_we, bus.im_waddr, bus.im_wdata, cpu_rst, busy, done, err, bus.in_ready);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0 || cpu_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b busy=%b cpu_rst=%b, required 1 0 0",
                     bus.in_ready, busy, cpu_rst);
        end
    endtask

    task automatic test_single;
        sb.push_back('{addr: 11'd0, data: 32'h0062E233});
        send_byte(8'hA5, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy: got %b, required 1", busy);
        end
        txq = {8'h01, 8'h00, 8'h33, 8'hE2, 8'h62, 8'h00};
        send_txq(1'b0);
        n_checks++;
        if (done !== 1'b0 || cpu_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early_done: got done=%b cpu_rst=%b, required 0 0", done, cpu_rst);
        end
        send_byte(8'hB3, 1'b0);
        n_checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_status: got done=%b cpu_rst=%b err=%b busy=%b, required 1 1 0 0",
                     done, cpu_rst, err, busy);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL single_writes: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_two_words;
        sb.push_back('{addr: 11'd0, data: 32'h00832383});
        sb.push_back('{addr: 11'd1, data: 32'hFFC4A303});
        send_byte(8'hA5, 1'b0);
        n_checks++;
        if (cpu_rst !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL two_restart: got cpu_rst=%b done=%b busy=%b, required 0 0 1", cpu_rst, done, busy);
        end
        // 83^23^83^00^03^A3^C4^FF = B8
        txq = {8'h02, 8'h00, 8'h83, 8'h23, 8'h83, 8'h00, 8'h03, 8'hA3, 8'hC4, 8'hFF, 8'hB8};
        send_txq(1'b0);
        n_checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL two_status: got done=%b cpu_rst=%b err=%b, required 1 1 0", done, cpu_rst, err);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL two_writes: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_bad_checksum;
        sb.push_back('{addr: 11'd0, data: 32'h0062E233});
        txq = {8'hA5, 8'h01, 8'h00, 8'h33, 8'hE2, 8'h62, 8'h00, 8'hB4};
        send_txq(1'b0);
        n_checks++;
        if (err !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_csum_status: got err=%b done=%b cpu_rst=%b, required 1 0 0", err, done, cpu_rst);
        end
        sb.push_back('{addr: 11'd0, data: 32'h0062E233});
        txq = {8'hA5, 8'h01, 8'h00, 8'h33, 8'hE2, 8'h62, 8'h00, 8'hB3};
        send_txq(1'b0);
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_csum_recover: got done=%b err=%b cpu_rst=%b, required 1 0 1", done, err, cpu_rst);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL bad_csum_writes: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_noise_empty;
        txq = {8'h00, 8'hFF, 8'h5A};
        send_txq(1'b0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || cpu_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL noise_ignored: got done=%b busy=%b cpu_rst=%b, required 1 0 1", done, busy, cpu_rst);
        end
        txq = {8'hA5, 8'h00, 8'h00};
        send_txq(1'b0);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_in_chk: got busy=%b done=%b, required 1 0", busy, done);
        end
        send_byte(8'h00, 1'b0);
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_status: got done=%b err=%b cpu_rst=%b, required 1 0 1", done, err, cpu_rst);
        end
    endtask

    task automatic test_over_length;
        txq = {8'hA5, 8'h01};
        send_txq(1'b0);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL over_len_early: got err=%b, required 0", err);
        end
        send_byte(8'h08, 1'b0);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cpu_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL over_len_status: got err=%b busy=%b done=%b cpu_rst=%b, required 1 0 0 0",
                     err, busy, done, cpu_rst);
        end
        send_byte(8'h11, 1'b0);
        repeat (6) @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL over_len_ignore: got err=%b busy=%b, required 1 0", err, busy);
        end
    endtask

    task automatic test_reset_mid_frame;
        txq = {8'hA5, 8'h01, 8'h00, 8'h33, 8'hE2};
        send_txq(1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.im_we, bus.im_waddr, bus.im_wdata, cpu_rst, busy, done, err, bus.in_ready} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got we=%b addr=%0d data=%h cpu_rst=%b busy=%b done=%b err=%b rdy=%b, required all 0",
                     bus.im_we, bus.im_waddr, bus.im_wdata, cpu_rst, busy, done, err, bus.in_ready);
        end
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        // Leftover data without SYNC must be dropped.
        txq = {8'h62, 8'h00};
        send_txq(1'b0);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_nosync: got busy=%b, required 0", busy);
        end
        sb.push_back('{addr: 11'd0, data: 32'h0062E233});
        txq = {8'hA5, 8'h01, 8'h00, 8'h33, 8'hE2, 8'h62, 8'h00, 8'hB3};
        send_txq(1'b1);
        n_checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_status: got done=%b cpu_rst=%b err=%b, required 1 1 0", done, cpu_rst, err);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL gaps_writes: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_words();
        test_bad_checksum();
        test_noise_empty();
        test_over_length();
        test_reset_mid_frame();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
